// File: rtl/frame_scheduler_pkg.sv
// Shared definitions for the frame scheduler: FSM state encoding, default
// frame length and the owner-index width helper.
package frame_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam int FRAME_LEN_DEF = 8;

    // Width of an owner index: at least one bit even for a single requester.
    function automatic int idw(input int n);
        if (n <= 2) begin
            return 1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/frame_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational request picker for the frame scheduler.
// Default: round-robin search starting at ptr.
// Build option SCHED_FIXED_PRIO_EN: fixed priority, lowest index wins, ptr ignored.
module rr_arbiter
    import frame_scheduler_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] gnt_next,
    output logic [IDW-1:0]     idx
);

    logic found_s;

`ifdef SCHED_FIXED_PRIO_EN
    logic unused_ptr_s;
    assign unused_ptr_s = ^ptr;
`endif

    // Scan the candidates in priority order and keep the first requester seen.
    always_comb begin
        gnt_next = '0;
        idx      = '0;
        found_s  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int c;
`ifdef SCHED_FIXED_PRIO_EN
            c = k;
`else
            c = int'(ptr) + k;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end else begin
                c = c;
            end
`endif
            if (req[c] && !found_s) begin
                found_s = 1'b1;
                idx     = IDW'(c);
            end else begin
                found_s = found_s;
            end
        end
        if (found_s) begin
            gnt_next[idx] = 1'b1;
        end else begin
            gnt_next = '0;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// frame_scheduler: shares one frame engine between NUM_REQ requesters.
// Arbitrates, forwards the owner's contiguous frame to the engine (one
// register stage), then returns the engine's result words tagged with the
// owner index.
// Build option SCHED_FIXED_PRIO_EN selects fixed priority in rr_arbiter;
// rr_ptr is then held at 0.
module frame_scheduler
    import frame_scheduler_pkg::*;
#(
    parameter  int NUM_REQ   = 2,
    parameter  int DATA_W    = 6,
    parameter  int FRAME_LEN = FRAME_LEN_DEF,
    localparam int IDW       = idw(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         eng_in_data,
    output logic                      eng_in_valid,
    input  logic [DATA_W-1:0]         eng_out_data,
    input  logic                      eng_out_valid,
    input  logic                      eng_done,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_valid,
    output logic [IDW-1:0]            out_id,
    output logic                      busy,
    output logic                      err_trunc
);

    localparam logic [3:0] LAST_CNT = 4'(FRAME_LEN);

    state_e              state_r;
    logic [IDW-1:0]      owner_r;
    logic [IDW-1:0]      rr_ptr_r;
    logic [3:0]          word_cnt_r;
    logic [NUM_REQ-1:0]  gnt_r;
    logic [DATA_W-1:0]   eng_in_data_r;
    logic                eng_in_valid_r;
    logic [DATA_W-1:0]   out_data_r;
    logic                out_valid_r;
    logic [IDW-1:0]      out_id_r;
    logic                busy_r;
    logic                err_trunc_r;

    logic [NUM_REQ-1:0]  arb_gnt_s;
    logic [IDW-1:0]      arb_idx_s;
    logic                owner_valid_s;
    logic                owner_req_s;
    logic [DATA_W-1:0]   owner_data_s;
    logic [IDW-1:0]      next_ptr_s;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req      (req),
        .ptr      (rr_ptr_r),
        .gnt_next (arb_gnt_s),
        .idx      (arb_idx_s)
    );

    // Select the current owner's request lines and compute the pointer after it.
    always_comb begin
        owner_valid_s = req_valid[owner_r];
        owner_req_s   = req[owner_r];
        owner_data_s  = req_data[int'(owner_r)*DATA_W +: DATA_W];
`ifdef SCHED_FIXED_PRIO_EN
        next_ptr_s    = '0;
`else
        if (owner_r == IDW'(NUM_REQ - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = owner_r + IDW'(1);
        end
`endif
    end

    // Scheduler FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= ST_IDLE;
            owner_r        <= '0;
            rr_ptr_r       <= '0;
            word_cnt_r     <= 4'd0;
            gnt_r          <= '0;
            eng_in_data_r  <= '0;
            eng_in_valid_r <= 1'b0;
            out_data_r     <= '0;
            out_valid_r    <= 1'b0;
            out_id_r       <= '0;
            busy_r         <= 1'b0;
            err_trunc_r    <= 1'b0;
        end else begin
            eng_in_valid_r <= 1'b0;
            out_valid_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (|req) begin
                        owner_r    <= arb_idx_s;
                        gnt_r      <= arb_gnt_s;
                        word_cnt_r <= 4'd0;
                        busy_r     <= 1'b1;
                        state_r    <= ST_SEND;
                    end else begin
                        gnt_r  <= '0;
                        busy_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (owner_valid_s) begin
                        eng_in_valid_r <= 1'b1;
                        eng_in_data_r  <= owner_data_s;
                        word_cnt_r     <= word_cnt_r + 4'd1;
                        if (word_cnt_r + 4'd1 == LAST_CNT) begin
                            gnt_r   <= '0;
                            state_r <= ST_WAIT;
                        end else begin
                            state_r <= ST_SEND;
                        end
                    end else if (word_cnt_r == 4'd0) begin
                        // Owner may still withdraw before committing a word.
                        if (!owner_req_s) begin
                            gnt_r   <= '0;
                            busy_r  <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_SEND;
                        end
                    end else begin
                        // Gap inside a frame: the frame is cut short.
                        err_trunc_r <= 1'b1;
                        gnt_r       <= '0;
                        state_r     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (eng_out_valid) begin
                        out_valid_r <= 1'b1;
                        out_data_r  <= eng_out_data;
                        out_id_r    <= owner_r;
                    end else begin
                        out_valid_r <= 1'b0;
                    end
                    if (eng_done) begin
                        rr_ptr_r <= next_ptr_s;
                        busy_r   <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                default: begin
                    gnt_r   <= '0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt          = gnt_r;
    assign eng_in_data  = eng_in_data_r;
    assign eng_in_valid = eng_in_valid_r;
    assign out_data     = out_data_r;
    assign out_valid    = out_valid_r;
    assign out_id       = out_id_r;
    assign busy         = busy_r;
    assign err_trunc    = err_trunc_r;

endmodule
